result_checker: RTL
===================

Name: result_checker

Overview:
- Synthesizable self-checking scoreboard; hardware successor to the simulation pass/fail task set.
- Compares expected vs measured words on NUM_CH parallel valid/ready channels.
- Counts tests and failures, enforces an expected test count and a cycle watchdog, and drives sticky pass/fail flags.
- Sits beside the DUT (SPI/accelerometer datapath) in on-FPGA self-test builds and in benches.

Parameters:
- NUM_CH, 2, number of independent compare channels.
- DATA_WIDTH, 32, width of each expected/measured word.
- NUM_TESTS, 16, number of compares required for PASS.
- TIMEOUT_CYCLES, 50000000, RUN-state cycle limit before forced FAIL.
- CNT_WIDTH, 16, width of test/fail counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- start_i  input  1  begin a test run; clears counters and flags.
- done_i  input  1  stimulus side declares all tests completed.
- ch_valid  input  NUM_CH  per-channel compare request.
- ch_ready  output  NUM_CH  per-channel accept.
- ch_expected  input  NUM_CH*DATA_WIDTH  packed expected words, channel 0 in LSBs.
- ch_measured  input  NUM_CH*DATA_WIDTH  packed measured words, channel 0 in LSBs.
- test_count  output  CNT_WIDTH  compares accepted this run.
- fail_count  output  CNT_WIDTH  mismatching compares this run.
- first_fail_ch  output  max(1,$clog2(NUM_CH))  channel of the first mismatch.
- first_fail_idx  output  CNT_WIDTH  test number of the first mismatch.
- test_passed  output  1  sticky PASS.
- test_failed  output  1  sticky FAIL.
- timeout  output  1  FAIL was caused by the watchdog.
- busy  output  1  high in RUN.

Behaviour:
- Reset: state IDLE; all outputs 0, including ch_ready.

States:
- IDLE: ch_ready=0. start_i → RUN, clearing counters, flags, first_fail_* and the watchdog.
- RUN: ch_ready all ones, busy=1.
- PASS: terminal; test_passed=1.
- FAIL: terminal; test_failed=1.
- From PASS or FAIL, start_i → RUN with a full clear. ch_ready=0 in both terminal states.

Handshake and compare:
- Accept on ch_valid & ch_ready.
- Accepted words are compared (!= on all bits) and results registered.
- Counters and flags update on the clock edge after the handshake (1-cycle latency).

Counting:
- test_count += popcount(accepted); fail_count += popcount(mismatch).
- Both counters saturate at all-ones with no wrap.
- Within one cycle, test numbering runs by ascending channel index.
- On the first mismatching cycle: first_fail_ch = lowest mismatching channel; first_fail_idx = test_count before the increment plus the rank of that channel among accepted channels. Both hold until the next start_i.

Transitions out of RUN:
- Registered mismatch → FAIL.
- Watchdog reaching TIMEOUT_CYCLES → FAIL, timeout=1.
- done_i → PASS if final test_count == NUM_TESTS and fail_count == 0, else FAIL. Final test_count includes that cycle's accepts.

Priority and boundary cases:
- Same-cycle events resolve as mismatch > timeout > done_i. Timeout is only flagged if no mismatch occurred.
- done_i or ch_valid in IDLE, PASS or FAIL: ignored.
- start_i in RUN: restarts the run with a full clear.
- rst mid-run: immediate return to the reset values.

Optional Feature:
- Macro: RESULT_CHECKER_MASK_EN.
- Defined: adds input ch_mask (NUM_CH*DATA_WIDTH). Compare becomes ((expected ^ measured) & mask) != 0; a zero mask always passes.
- Undefined: no ch_mask port; full-width compare.

Decomposition:
- Package result_checker_pkg holds:
  - state enum (IDLE, RUN, PASS, FAIL);
  - popcount and first-set functions;
  - default parameter constants.
- One sub-module: result_checker_watchdog (enable/clear/expire counter, width $clog2(TIMEOUT_CYCLES+1)).

Test Plan:
- NUM_CH=2, NUM_TESTS=4: two cycles of both channels valid, all matching, then done_i → test_count=4, fail_count=0, test_passed=1 one cycle later.
- Channel 1 measured 0xDEADBEEF vs expected 0xDEADBEEE on the 2nd cycle (tests 2,3) → test_failed=1, fail_count=1, first_fail_ch=1, first_fail_idx=3.
- 3 matching compares then done_i with NUM_TESTS=4 → test_failed=1, timeout=0.
- TIMEOUT_CYCLES=100, start_i, no traffic → test_failed=1 and timeout=1 at cycle 100 after start.
- rst asserted mid-RUN with test_count=2 → all outputs 0 asynchronously. Then start_i and 4 matching compares plus done_i → PASS.
- MASK_EN built, mask 0xFFFF0000, expected 0x12340000 vs measured 0x1234ABCD → counted as pass, fail_count=0.

Source files
------------

// File: rtl/result_checker_pkg.sv
// result_checker_pkg: shared types, defaults and helpers for result_checker.
//   state_t    : run-control states of the checker
//   popcount   : number of set bits in a MAX_CH-wide vector
//   first_set  : index of the lowest set bit (0 when the vector is zero)
package result_checker_pkg;

  localparam int unsigned MAX_CH             = 32;
  localparam int unsigned DEF_NUM_CH         = 2;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_NUM_TESTS      = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 50000000;
  localparam int unsigned DEF_CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  function automatic int unsigned popcount(input logic [MAX_CH-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  function automatic int unsigned first_set(input logic [MAX_CH-1:0] v);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (v[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/result_checker_watchdog.sv
// result_checker_watchdog: run-time cycle limit for result_checker.
//   clk, rst  : clock, asynchronous active-high reset
//   i_en      : count this cycle (checker is running)
//   i_clr     : restart the count from zero (takes priority)
//   o_expired : high during the TIMEOUT_CYCLES-th enabled cycle, so the
//               owner leaves RUN on the edge TIMEOUT_CYCLES cycles after start
module result_checker_watchdog
  import result_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/result_checker.sv
// result_checker: hardware scoreboard comparing expected vs measured words.
// Optional feature macro: RESULT_CHECKER_MASK_EN (adds ch_mask, masked compare).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : begin/restart a run (clears counters and flags)
//   done_i          : stimulus side has issued all tests
//   ch_valid/ready  : per-channel compare handshake (ready high only in RUN)
//   ch_expected     : packed expected words, channel 0 in LSBs
//   ch_measured     : packed measured words, channel 0 in LSBs
//   ch_mask         : packed compare masks (RESULT_CHECKER_MASK_EN only)
//   test_count      : compares accepted this run (saturating)
//   fail_count      : mismatching compares this run (saturating)
//   first_fail_ch   : channel of the first mismatch
//   first_fail_idx  : test number (0-based) of the first mismatch
//   test_passed     : sticky PASS
//   test_failed     : sticky FAIL
//   timeout         : FAIL came from the watchdog
//   busy            : high in RUN
module result_checker
  import result_checker_pkg::*;
#(
  parameter int unsigned NUM_CH         = DEF_NUM_CH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned NUM_TESTS      = DEF_NUM_TESTS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
  localparam int unsigned FCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         done_i,
  input  logic [NUM_CH-1:0]            ch_valid,
  output logic [NUM_CH-1:0]            ch_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_expected,
`ifdef RESULT_CHECKER_MASK_EN
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_mask,
`endif
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_measured,
  output logic [CNT_WIDTH-1:0]         test_count,
  output logic [CNT_WIDTH-1:0]         fail_count,
  output logic [FCH_W-1:0]             first_fail_ch,
  output logic [CNT_WIDTH-1:0]         first_fail_idx,
  output logic                         test_passed,
  output logic                         test_failed,
  output logic                         timeout,
  output logic                         busy
);

  localparam int unsigned SUM_W = CNT_WIDTH + 8;

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_test_count, r_fail_count, r_first_fail_idx;
  logic [FCH_W-1:0]      r_first_fail_ch;
  logic                  r_timeout;

  logic [NUM_CH-1:0]     w_acc, w_mis;
  logic [MAX_CH-1:0]     w_acc_x, w_mis_x, w_below;
  int unsigned           w_first_ch, w_rank;
  logic [SUM_W-1:0]      w_tc_sum, w_fc_sum, w_idx_sum;
  logic [CNT_WIDTH-1:0]  w_tc_nxt, w_fc_nxt, w_idx_nxt;
  logic                  w_wd_expired;
  logic                  w_clear, w_run_upd, w_rec_first, w_set_timeout;

  assign w_acc = ch_valid & ch_ready;

  always_comb begin
    w_mis = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
`ifdef RESULT_CHECKER_MASK_EN
      w_mis[c] = w_acc[c] & (|((ch_expected[c*DATA_WIDTH +: DATA_WIDTH] ^
                                ch_measured[c*DATA_WIDTH +: DATA_WIDTH]) &
                               ch_mask[c*DATA_WIDTH +: DATA_WIDTH]));
`else
      w_mis[c] = w_acc[c] & (ch_expected[c*DATA_WIDTH +: DATA_WIDTH] !=
                             ch_measured[c*DATA_WIDTH +: DATA_WIDTH]);
`endif
    end
  end

  // Test numbers are handed out by ascending channel, so the first failing
  // test number is the old count plus the accepted channels below it.
  always_comb begin
    w_acc_x              = '0;
    w_mis_x              = '0;
    w_acc_x[NUM_CH-1:0]  = w_acc;
    w_mis_x[NUM_CH-1:0]  = w_mis;
    w_first_ch           = first_set(w_mis_x);
    w_below              = (MAX_CH'(1) << w_first_ch) - MAX_CH'(1);
    w_rank               = popcount(w_acc_x & w_below);
    w_tc_sum  = SUM_W'(r_test_count) + SUM_W'(popcount(w_acc_x));
    w_fc_sum  = SUM_W'(r_fail_count) + SUM_W'(popcount(w_mis_x));
    w_idx_sum = SUM_W'(r_test_count) + SUM_W'(w_rank);
    w_tc_nxt  = (|w_tc_sum[SUM_W-1:CNT_WIDTH])  ? '1 : w_tc_sum[CNT_WIDTH-1:0];
    w_fc_nxt  = (|w_fc_sum[SUM_W-1:CNT_WIDTH])  ? '1 : w_fc_sum[CNT_WIDTH-1:0];
    w_idx_nxt = (|w_idx_sum[SUM_W-1:CNT_WIDTH]) ? '1 : w_idx_sum[CNT_WIDTH-1:0];
  end

  result_checker_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_state == ST_RUN),
    .i_clr    (start_i),
    .o_expired(w_wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clear       = 1'b0;
    w_run_upd     = 1'b0;
    w_rec_first   = 1'b0;
    w_set_timeout = 1'b0;
    if (start_i) begin
      w_state_nxt = ST_RUN;
      w_clear     = 1'b1;
    end else if (r_state == ST_RUN) begin
      w_run_upd = 1'b1;
      if (|w_mis) begin
        w_state_nxt = ST_FAIL;
        w_rec_first = 1'b1;
      end else if (w_wd_expired) begin
        w_state_nxt   = ST_FAIL;
        w_set_timeout = 1'b1;
      end else if (done_i) begin
        w_state_nxt = ((w_tc_nxt == CNT_WIDTH'(NUM_TESTS)) && (w_fc_nxt == '0))
                      ? ST_PASS : ST_FAIL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_test_count     <= '0;
      r_fail_count     <= '0;
      r_first_fail_ch  <= '0;
      r_first_fail_idx <= '0;
      r_timeout        <= 1'b0;
    end else if (w_clear) begin
      r_test_count     <= '0;
      r_fail_count     <= '0;
      r_first_fail_ch  <= '0;
      r_first_fail_idx <= '0;
      r_timeout        <= 1'b0;
    end else if (w_run_upd) begin
      r_test_count <= w_tc_nxt;
      r_fail_count <= w_fc_nxt;
      if (w_rec_first) begin
        r_first_fail_ch  <= FCH_W'(w_first_ch);
        r_first_fail_idx <= w_idx_nxt;
      end
      if (w_set_timeout) r_timeout <= 1'b1;
    end
  end

  assign ch_ready       = {NUM_CH{r_state == ST_RUN}};
  assign busy           = (r_state == ST_RUN);
  assign test_passed    = (r_state == ST_PASS);
  assign test_failed    = (r_state == ST_FAIL);
  assign test_count     = r_test_count;
  assign fail_count     = r_fail_count;
  assign first_fail_ch  = r_first_fail_ch;
  assign first_fail_idx = r_first_fail_idx;
  assign timeout        = r_timeout;

endmodule
